// File: rtl/risc16_pkg.sv
// risc16_pkg -- shared definitions for the RiSC-16 control sequencer.
//   Opcodes, ALU function codes, register-write source codes, the sequencer
//   state encoding, the decode-class encoding and the decoded-control struct
//   passed from risc16_decode to risc16_ctrl.
package risc16_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam logic [1:0] FUNC_ADD  = 2'b00;
  localparam logic [1:0] FUNC_NAND = 2'b01;
  localparam logic [1:0] FUNC_PASS = 2'b10;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC1 = 2'b10;

  typedef enum logic [2:0] {
    BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  // What EXEC hands off to: writeback, memory store/load, branch, jump.
  typedef enum logic [2:0] {
    CLS_ALU, CLS_STORE, CLS_LOAD, CLS_BRANCH, CLS_JUMP
  } cls_t;

  typedef struct packed {
    logic [2:0] rd1;
    logic [2:0] rd2;
    logic       mux1;
    logic       mux2;
    logic [1:0] func;
    logic [9:0] imm;
    logic [1:0] wsel;
    cls_t       cls;
    logic       halt;   // JALR that parks the core (only with the halt build)
  } dec_t;

  // Branch offset: 7-bit two's complement field to 16 bits.
  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

endpackage

// File: rtl/risc16_decode.sv
// risc16_decode -- purely combinational instruction decode.
//   ir  : in  16  instruction register
//   dec : out dec_t  read addresses, ALU controls, imm, write source,
//                    EXEC successor class and halt request
// Build option: RISC16_HALT_EN -- when defined, JALR with IR[6:0]!=0 raises
//   dec.halt; otherwise dec.halt is constant 0 and JALR is always ordinary.
module risc16_decode
  import risc16_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic [2:0] op, ra, rb, rc;

  assign op = ir[15:13];
  assign ra = ir[12:10];
  assign rb = ir[9:7];
  assign rc = ir[2:0];

  always_comb begin
    dec      = '0;
    dec.imm  = ir[9:0];
    dec.func = FUNC_ADD;
    dec.wsel = WSEL_ALU;
    dec.cls  = CLS_ALU;
    case (op)
      OP_ADD: begin
        dec.rd1 = rb;
        dec.rd2 = rc;
      end
      OP_ADDI: begin
        dec.rd1  = rb;
        dec.mux2 = 1'b1;
      end
      OP_NAND: begin
        dec.rd1  = rb;
        dec.rd2  = rc;
        dec.func = FUNC_NAND;
      end
      OP_LUI: begin
        dec.mux1 = 1'b1;
        dec.func = FUNC_PASS;
      end
      OP_SW: begin
        // rd2 carries the store data (rA), address is rB + imm
        dec.rd1  = rb;
        dec.rd2  = ra;
        dec.mux2 = 1'b1;
        dec.cls  = CLS_STORE;
      end
      OP_LW: begin
        dec.rd1  = rb;
        dec.mux2 = 1'b1;
        dec.wsel = WSEL_MEM;
        dec.cls  = CLS_LOAD;
      end
      OP_BEQ: begin
        dec.rd1 = ra;
        dec.rd2 = rb;
        dec.cls = CLS_BRANCH;
      end
      OP_JALR: begin
        // ALU passes rB through; that value is the jump target
        dec.rd1  = rb;
        dec.func = FUNC_PASS;
        dec.wsel = WSEL_PC1;
        dec.cls  = CLS_JUMP;
`ifdef RISC16_HALT_EN
        dec.halt = (ir[6:0] != 7'd0);
`else
        dec.halt = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/risc16_ctrl.sv
// risc16_ctrl -- multi-cycle control sequencer for the RiSC-16 core.
//   Owns PC and IR; sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req/addr/valid/rdata     instruction fetch handshake (addr = pc)
//   dmem_req/we/ready             data access handshake
//   rf_rd1_addr, rf_rd2_addr      register read ports
//   rf_we, rf_wa, rf_wsel         register write (wsel 00 ALU, 01 mem, 10 PC+1)
//   MUX_alu1, MUX_alu2, FUNC_alu, imm   ALU control
//   EQ, alu_out                   ALU results (branch compare, JALR target)
//   pc, halted                    current PC, core halted
// Build option: RISC16_HALT_EN -- JALR with IR[6:0]!=0 enters HALT, left only
//   by reset. Without it, halted is tied to 0.
module risc16_ctrl
  import risc16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic [2:0]  rf_rd1_addr,
  output logic [2:0]  rf_rd2_addr,
  output logic        rf_we,
  output logic [2:0]  rf_wa,
  output logic [1:0]  rf_wsel,
  output logic        MUX_alu1,
  output logic        MUX_alu2,
  output logic [1:0]  FUNC_alu,
  output logic [9:0]  imm,
  input  logic        EQ,
  input  logic [15:0] alu_out,
  output logic [15:0] pc,
  output logic        halted
);

  state_t      state, state_nxt;
  logic [15:0] ir, pc_q, pc1;
  logic        pc_ld;
  logic [15:0] pc_nxt;
  dec_t        dec;

  risc16_decode u_dec (
    .ir  (ir),
    .dec (dec)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:   state_nxt = FETCH;
      FETCH:  if (imem_valid) state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC: begin
        case (dec.cls)
          CLS_BRANCH:           state_nxt = FETCH;
          CLS_STORE, CLS_LOAD:  state_nxt = MEM;
          CLS_JUMP:             state_nxt = dec.halt ? HALT : WB;
          default:              state_nxt = WB;
        endcase
      end
      MEM:    if (dmem_ready) state_nxt = (dec.cls == CLS_LOAD) ? WB : FETCH;
      WB:     state_nxt = FETCH;
      HALT:   state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    imem_req = (state == FETCH);
    dmem_req = (state == MEM);
    dmem_we  = (state == MEM) && (dec.cls == CLS_STORE);
    // r0 is hardwired to zero, so a write to it is suppressed here
    rf_we    = (state == WB) && (ir[12:10] != 3'd0);
  end

  // ALU controls and addresses follow IR directly; IR resets to 0 (ADD r0,r0,r0)
  // so every control reads as 0 out of reset.
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign rf_rd1_addr = dec.rd1;
  assign rf_rd2_addr = dec.rd2;
  assign rf_wa       = ir[12:10];
  assign rf_wsel     = dec.wsel;
  assign MUX_alu1    = dec.mux1;
  assign MUX_alu2    = dec.mux2;
  assign FUNC_alu    = dec.func;
  assign imm         = dec.imm;

`ifdef RISC16_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  // ---- PC update: each instruction commits its PC in its final state ----
  // JALR commits alu_out in EXEC, so its WB must leave pc alone. A halting
  // JALR never commits: pc stays on the halting instruction.
  always_comb begin
    pc_ld  = 1'b0;
    pc_nxt = pc1;
    case (state)
      EXEC: begin
        if (dec.cls == CLS_BRANCH) begin
          pc_ld  = 1'b1;
          pc_nxt = EQ ? (pc1 + sext7(ir[6:0])) : pc1;
        end else if (dec.cls == CLS_JUMP && !dec.halt) begin
          pc_ld  = 1'b1;
          pc_nxt = alu_out;
        end
      end
      MEM:     pc_ld = (dec.cls == CLS_STORE) && dmem_ready;
      WB:      pc_ld = (dec.cls != CLS_JUMP);
      default: pc_ld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      pc1  <= RESET_PC;
      ir   <= '0;
    end else begin
      if (state == FETCH && imem_valid) begin
        ir  <= imem_rdata;
        pc1 <= pc_q + 16'd1;
      end
      if (pc_ld) pc_q <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_risc16_ctrl.sv
// tb_risc16_ctrl -- directed, table-driven bench for risc16_ctrl.
module tb_risc16_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_valid = 1'b0;
  logic [15:0] imem_addr, imem_rdata = 16'h0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [2:0]  rf_rd1_addr, rf_rd2_addr, rf_wa;
  logic        rf_we;
  logic [1:0]  rf_wsel, FUNC_alu;
  logic        MUX_alu1, MUX_alu2;
  logic [9:0]  imm;
  logic        EQ = 1'b0;
  logic [15:0] alu_out = 16'h0;
  logic [15:0] pc;
  logic        halted;

  always #5 clk = ~clk;

  risc16_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wsel(rf_wsel),
    .MUX_alu1(MUX_alu1), .MUX_alu2(MUX_alu2), .FUNC_alu(FUNC_alu), .imm(imm),
    .EQ(EQ), .alu_out(alu_out), .pc(pc), .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [2:0]  rd1, rd2;
    logic        m1, m2;
    logic [1:0]  func;
    logic [9:0]  imm;
    int          we_n;
    logic [2:0]  wa;
    logic [1:0]  wsel;
    int          dreq_n;
    logic        dwe;
    logic [15:0] pc_start, pc_end;
    int          ireq_n;
    logic        addr_ok;
    logic        timeout;
  } obs_t;

  typedef struct {
    logic [15:0] instr;
    int          idly, ddly;
    logic        eq;
    logic [15:0] alu;
    int          cyc;
    logic [2:0]  rd1, rd2;
    logic        m1, m2;
    logic [1:0]  func;
    logic [9:0]  imm;
    int          we_n;
    logic [2:0]  wa;
    logic [1:0]  wsel;
    int          dreq_n;
    logic        dwe;
    logic [15:0] pc_end;
  } vec_t;

  // Runs one instruction starting in FETCH; returns when the next fetch begins
  // (or the core halts). Fetch/data waits are inserted per idly/ddly.
  task automatic run_instr(input logic [15:0] instr, input int idly, input int ddly,
                           input logic eq, input logic [15:0] alu, output obs_t o);
    int   iw, dw;
    logic got, dec_seen;
    o.cyc = 0; o.rd1 = 0; o.rd2 = 0; o.m1 = 0; o.m2 = 0; o.func = 0; o.imm = 0;
    o.we_n = 0; o.wa = 0; o.wsel = 0; o.dreq_n = 0; o.dwe = 0;
    o.pc_start = 0; o.pc_end = 0; o.ireq_n = 0; o.addr_ok = 1; o.timeout = 1;
    iw = 0; dw = 0; got = 0; dec_seen = 0;
    EQ = eq; alu_out = alu;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      imem_valid = 1'b0;
      dmem_ready = 1'b0;
      if (got && (imem_req || halted)) begin
        o.timeout = 0;
        break;
      end
      o.cyc++;
      if (imem_req) begin
        if (o.ireq_n == 0) o.pc_start = pc;
        o.ireq_n++;
        if (imem_addr !== o.pc_start) o.addr_ok = 0;
        if (iw == idly) begin
          imem_valid = 1'b1; imem_rdata = instr; got = 1;
        end else begin
          iw++; imem_rdata = 16'hDEAD;
        end
      end else if (got && !dec_seen) begin
        dec_seen = 1;
        o.rd1 = rf_rd1_addr; o.rd2 = rf_rd2_addr; o.m1 = MUX_alu1; o.m2 = MUX_alu2;
        o.func = FUNC_alu; o.imm = imm; o.wa = rf_wa; o.wsel = rf_wsel;
      end
      if (dmem_req) begin
        o.dreq_n++;
        o.dwe = o.dwe | dmem_we;
        if (dw == ddly) dmem_ready = 1'b1;
        else dw++;
      end
      if (rf_we) o.we_n++;
    end
    o.pc_end = pc;
  endtask

  vec_t vt[17];
  obs_t o;

  initial begin
    //            instr   id dd eq  alu      cyc rd1 rd2 m1 m2 fn imm     we wa wsel dq dwe pc_end
    vt[0]  = '{16'h2405, 0, 0, 1'b0, 16'h0000, 4, 3'd0, 3'd0, 1'b0, 1'b1, 2'd0, 10'h005, 1, 3'd1, 2'd0, 0, 1'b0, 16'h0001};
    vt[1]  = '{16'h0503, 3, 0, 1'b0, 16'h0000, 7, 3'd2, 3'd3, 1'b0, 1'b0, 2'd0, 10'h103, 1, 3'd1, 2'd0, 0, 1'b0, 16'h0002};
    vt[2]  = '{16'h77FF, 0, 0, 1'b0, 16'h0000, 4, 3'd0, 3'd0, 1'b1, 1'b0, 2'd2, 10'h3FF, 1, 3'd5, 2'd0, 0, 1'b0, 16'h0003};
    vt[3]  = '{16'hAC82, 0, 2, 1'b0, 16'h0000, 7, 3'd1, 3'd0, 1'b0, 1'b1, 2'd0, 10'h082, 1, 3'd3, 2'd1, 3, 1'b0, 16'h0004};
    vt[4]  = '{16'h8C82, 0, 1, 1'b0, 16'h0000, 5, 3'd1, 3'd3, 1'b0, 1'b1, 2'd0, 10'h082, 0, 3'd3, 2'd0, 2, 1'b1, 16'h0005};
    vt[5]  = '{16'h4A85, 0, 0, 1'b0, 16'h0000, 4, 3'd5, 3'd5, 1'b0, 1'b0, 2'd1, 10'h285, 1, 3'd2, 2'd0, 0, 1'b0, 16'h0006};
    vt[6]  = '{16'hE100, 0, 0, 1'b0, 16'h0010, 4, 3'd2, 3'd0, 1'b0, 1'b0, 2'd2, 10'h100, 0, 3'd0, 2'd2, 0, 1'b0, 16'h0010};
    vt[7]  = '{16'hC4FE, 0, 0, 1'b1, 16'h0000, 3, 3'd1, 3'd1, 1'b0, 1'b0, 2'd0, 10'h0FE, 0, 3'd1, 2'd0, 0, 1'b0, 16'h000F};
    vt[8]  = '{16'hC4FE, 0, 0, 1'b0, 16'h0000, 3, 3'd1, 3'd1, 1'b0, 1'b0, 2'd0, 10'h0FE, 0, 3'd1, 2'd0, 0, 1'b0, 16'h0010};
    vt[9]  = '{16'hC4FE, 0, 0, 1'b0, 16'h0000, 3, 3'd1, 3'd1, 1'b0, 1'b0, 2'd0, 10'h0FE, 0, 3'd1, 2'd0, 0, 1'b0, 16'h0011};
    vt[10] = '{16'hFD00, 0, 0, 1'b0, 16'h0020, 4, 3'd2, 3'd0, 1'b0, 1'b0, 2'd2, 10'h100, 1, 3'd7, 2'd2, 0, 1'b0, 16'h0020};
    vt[11] = '{16'hFD00, 0, 0, 1'b0, 16'h1234, 4, 3'd2, 3'd0, 1'b0, 1'b0, 2'd2, 10'h100, 1, 3'd7, 2'd2, 0, 1'b0, 16'h1234};
    vt[12] = '{16'h0100, 0, 0, 1'b0, 16'h0000, 4, 3'd2, 3'd0, 1'b0, 1'b0, 2'd0, 10'h100, 0, 3'd0, 2'd0, 0, 1'b0, 16'h1235};
    vt[13] = '{16'hFD00, 0, 0, 1'b0, 16'hFFFF, 4, 3'd2, 3'd0, 1'b0, 1'b0, 2'd2, 10'h100, 1, 3'd7, 2'd2, 0, 1'b0, 16'hFFFF};
    vt[14] = '{16'h2405, 0, 0, 1'b0, 16'h0000, 4, 3'd0, 3'd0, 1'b0, 1'b1, 2'd0, 10'h005, 1, 3'd1, 2'd0, 0, 1'b0, 16'h0000};
    vt[15] = '{16'hFD00, 0, 0, 1'b0, 16'h0077, 4, 3'd2, 3'd0, 1'b0, 1'b0, 2'd2, 10'h100, 1, 3'd7, 2'd2, 0, 1'b0, 16'h0077};
    vt[16] = '{16'hC403, 0, 0, 1'b1, 16'h0000, 3, 3'd1, 3'd0, 1'b0, 1'b0, 2'd0, 10'h003, 0, 3'd1, 2'd0, 0, 1'b0, 16'h007B};

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_halted", halted, 0);
    chk("rst_alu_ctl", {MUX_alu1, MUX_alu2, FUNC_alu, imm}, 0);
    rst_n = 1'b1;
    #1 chk("boot_no_req", imem_req, 0);

    // ---- table ----
    for (int i = 0; i < 17; i++) begin
      run_instr(vt[i].instr, vt[i].idly, vt[i].ddly, vt[i].eq, vt[i].alu, o);
      chk($sformatf("v%0d_timeout", i), o.timeout, 0);
      chk($sformatf("v%0d_cycles", i), o.cyc, vt[i].cyc);
      chk($sformatf("v%0d_ireq_n", i), o.ireq_n, vt[i].idly + 1);
      chk($sformatf("v%0d_addr_hold", i), o.addr_ok, 1);
      chk($sformatf("v%0d_rd1", i), o.rd1, vt[i].rd1);
      chk($sformatf("v%0d_rd2", i), o.rd2, vt[i].rd2);
      chk($sformatf("v%0d_mux", i), {o.m1, o.m2}, {vt[i].m1, vt[i].m2});
      chk($sformatf("v%0d_func", i), o.func, vt[i].func);
      chk($sformatf("v%0d_imm", i), o.imm, vt[i].imm);
      chk($sformatf("v%0d_we_n", i), o.we_n, vt[i].we_n);
      chk($sformatf("v%0d_wa", i), o.wa, vt[i].wa);
      chk($sformatf("v%0d_wsel", i), o.wsel, vt[i].wsel);
      chk($sformatf("v%0d_dreq_n", i), o.dreq_n, vt[i].dreq_n);
      chk($sformatf("v%0d_dwe", i), o.dwe, vt[i].dwe);
      chk($sformatf("v%0d_pc", i), o.pc_end, vt[i].pc_end);
    end

    // ---- reset while a load waits in MEM ----
    imem_valid = 1'b1; imem_rdata = 16'hAC82;
    @(negedge clk); imem_valid = 1'b0;           // DECODE
    @(negedge clk);                               // EXEC
    @(negedge clk);                               // MEM, ready held low
    chk("mid_dreq", dmem_req, 1);
    chk("mid_pc_before", pc, 16'h007B);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_dreq_drop", dmem_req, 0);
    chk("mid_rf_we", rf_we, 0);
    chk("mid_pc", pc, 16'h0000);
    chk("mid_mux2", MUX_alu2, 0);
    @(negedge clk);
    chk("mid_held", {imem_req, dmem_req, rf_we}, 0);
    rst_n = 1'b1;

    // ---- JALR with nonzero IR[6:0] ----
    run_instr(16'hE001, 0, 0, 1'b0, 16'h0042, o);
    chk("j1_timeout", o.timeout, 0);
    chk("j1_we_n", o.we_n, 0);
`ifdef RISC16_HALT_EN
    chk("halt_cycles", o.cyc, 3);
    chk("halt_flag", halted, 1);
    chk("halt_pc", o.pc_end, 16'h0000);
    begin
      logic busy;
      busy = 1'b0;
      repeat (6) begin
        @(negedge clk);
        busy = busy | imem_req | dmem_req | rf_we;
      end
      chk("halt_quiet", busy, 0);
      chk("halt_pc_frozen", pc, 16'h0000);
      chk("halt_stays", halted, 1);
    end
`else
    chk("j1_cycles", o.cyc, 4);
    chk("j1_pc", o.pc_end, 16'h0042);
    chk("j1_wsel", o.wsel, 2'd2);
    chk("j1_halted", halted, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
